// File: rtl/ex_muldiv.sv
// Iterative MIPS mult/multu/div/divu unit for the EX stage with mthi/mtlo access.
// One shift-add or restoring shift-subtract step per cycle on operand magnitudes, then sign fix-up.
module ex_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             hiWrite,
   input  logic             loWrite,
   input  logic [WIDTH-1:0] wData,
   input  logic             cancel,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic               is_div;
   logic               neg_res;
   logic               neg_rem;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   rem_r;
   logic [WIDTH-1:0]   quo_r;
   logic [2*WIDTH-1:0] prod_r;

   logic               sgn_op;
   logic               sgn_a;
   logic               sgn_b;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic               rem_ge;
   logic [WIDTH-1:0]   rem_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   always_comb begin
      sgn_op   = ~op[0];
      sgn_a    = sgn_op & srcA[WIDTH-1];
      sgn_b    = sgn_op & srcB[WIDTH-1];
      a_abs    = sgn_a ? -srcA : srcA;
      b_abs    = sgn_b ? -srcB : srcB;
      // multiplier bits are consumed from b_r's LSB; product shifts right into prod_r's low half
      mul_sum  = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + (b_r[0] ? {1'b0, a_r} : '0);
      // dividend bits are consumed from a_r's MSB into the partial remainder
      rem_sh   = {rem_r, a_r[WIDTH-1]};
      rem_ge   = (rem_sh >= {1'b0, b_r});
      rem_diff = rem_sh[WIDTH-1:0] - b_r;
      prod_fix = neg_res ? -prod_r : prod_r;
      quo_fix  = neg_res ? -quo_r : quo_r;
      rem_fix  = neg_rem ? -rem_r : rem_r;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         a_r     <= '0;
         b_r     <= '0;
         rem_r   <= '0;
         quo_r   <= '0;
         prod_r  <= '0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_div  <= op[1];
                  // a zero divisor yields an all-ones quotient that must not be negated
                  neg_res <= (sgn_a ^ sgn_b) & ~(op[1] & (srcB == '0));
                  neg_rem <= sgn_a;
                  a_r     <= a_abs;
                  b_r     <= b_abs;
                  prod_r  <= '0;
                  rem_r   <= '0;
                  quo_r   <= '0;
                  cnt     <= '0;
                  state   <= CALC;
               end else begin
                  if (hiWrite) hi <= wData;
                  if (loWrite) lo <= wData;
               end
            end
            CALC: begin
               if (cancel) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (is_div) begin
                     a_r   <= a_r << 1;
                     rem_r <= rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
                     quo_r <= {quo_r[WIDTH-2:0], rem_ge};
                  end else begin
                     prod_r <= {mul_sum, prod_r[WIDTH-1:1]};
                     b_r    <= b_r >> 1;
                  end
                  if (cnt == CW'(WIDTH - 1)) state <= FIX;
               end
            end
            FIX: begin
               if (cancel) begin
                  state <= IDLE;
               end else begin
                  if (is_div) begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end else begin
                     hi <= prod_fix[2*WIDTH-1:WIDTH];
                     lo <= prod_fix[WIDTH-1:0];
                  end
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: arithmetic results, latency, busy/done
// behaviour, mt priority, cancel and asynchronous reset.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        hiWrite;
   logic        loWrite;
   logic [31:0] wData;
   logic        cancel;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   ex_muldiv #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .srcA    (srcA),
      .srcB    (srcB),
      .hiWrite (hiWrite),
      .loWrite (loWrite),
      .wData   (wData),
      .cancel  (cancel),
      .hi      (hi),
      .lo      (lo),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      srcA  = a;
      srcB  = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // counts busy cycles until idle, plus every done pulse seen during and just after
   task automatic wait_idle(output int cyc, output int ndone);
      cyc   = 0;
      ndone = 0;
      while (busy && cyc < 200) begin
         if (done) ndone++;
         @(negedge clk);
         cyc++;
      end
      for (int i = 0; i < 3; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int cyc;
      int nd;
      start_op(o, a, b);
      wait_idle(cyc, nd);
      check({tag, "_busy_cycles"}, cyc, 33);
      check({tag, "_done_count"}, nd, 1);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
   endtask

   initial begin
      int cyc;
      int nd;
      rst     = 1'b1;
      start   = 1'b0;
      op      = 2'b00;
      srcA    = '0;
      srcB    = '0;
      hiWrite = 1'b0;
      loWrite = 1'b0;
      wData   = '0;
      cancel  = 1'b0;
      #1;
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      @(negedge clk);
      rst = 1'b0;

      run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
      run_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu_zero", OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
      run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      run_op("div_zero_neg", OP_DIV, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
      run_op("divu_big",  OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC);

      // mthi / mtlo preload in IDLE
      @(negedge clk);
      hiWrite = 1'b1;
      wData   = 32'h11111111;
      @(negedge clk);
      hiWrite = 1'b0;
      loWrite = 1'b1;
      wData   = 32'h22222222;
      @(negedge clk);
      loWrite = 1'b0;
      check("mthi", hi, 32'h11111111);
      check("mtlo", lo, 32'h22222222);

      // start and mthi while busy must be ignored
      start_op(OP_MULTU, 32'd3, 32'd4);
      repeat (4) @(negedge clk);
      start   = 1'b1;
      op      = OP_DIV;
      srcA    = 32'd100;
      srcB    = 32'd5;
      hiWrite = 1'b1;
      wData   = 32'hDEADBEEF;
      @(negedge clk);
      start   = 1'b0;
      hiWrite = 1'b0;
      check("busy_hi_hold", hi, 32'h11111111);
      check("busy_lo_hold", lo, 32'h22222222);
      wait_idle(cyc, nd);
      check("busy_ignore_cycles", cyc, 28);
      check("busy_ignore_done", nd, 1);
      check("busy_ignore_hi", hi, 32'h0);
      check("busy_ignore_lo", lo, 32'd12);

      // start beats mtlo in the same IDLE cycle
      @(negedge clk);
      start   = 1'b1;
      op      = OP_MULTU;
      srcA    = 32'd2;
      srcB    = 32'd3;
      loWrite = 1'b1;
      wData   = 32'h55555555;
      @(negedge clk);
      start   = 1'b0;
      loWrite = 1'b0;
      check("prio_busy", busy, 1);
      check("prio_lo_unwritten", lo, 32'd12);
      wait_idle(cyc, nd);
      check("prio_cycles", cyc, 33);
      check("prio_lo", lo, 32'd6);
      check("prio_hi", hi, 32'd0);

      // cancel in CALC
      start_op(OP_MULTU, 32'hFFFFFFFF, 32'd2);
      repeat (9) @(negedge clk);
      check("cancel_pre_busy", busy, 1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      check("cancel_busy", busy, 0);
      check("cancel_hi", hi, 32'd0);
      check("cancel_lo", lo, 32'd6);
      nd = 0;
      for (int i = 0; i < 5; i++) begin
         if (done) nd++;
         @(negedge clk);
      end
      check("cancel_no_done", nd, 0);
      check("cancel_lo_after", lo, 32'd6);

      run_op("after_cancel", OP_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);

      // asynchronous reset between edges mid-CALC
      start_op(OP_MULTU, 32'd5, 32'd7);
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("areset_busy", busy, 0);
      check("areset_hi", hi, 32'h0);
      check("areset_lo", lo, 32'h0);
      check("areset_done", done, 0);
      #1;
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      check("areset_stays_idle", nd, 0);
      check("areset_lo_after", lo, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched operands (readData1/readData2) and a decoded mult/div op from that register.
- Computes MIPS mult/multu/div/divu into HI/LO iteratively and supports mthi/mtlo.
- Drives busy so hazard logic can stall IF/ID/EX while an operation is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request; sampled only in IDLE
op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start
srcA  input  WIDTH  rs operand (multiplicand / dividend)
srcB  input  WIDTH  rt operand (multiplier / divisor)
hiWrite  input  1  mthi: write wData to HI
loWrite  input  1  mtlo: write wData to LO
wData  input  WIDTH  mthi/mtlo data
cancel  input  1  flush in-flight operation (exception/branch flush)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  operation in flight
done  output  1  one-cycle pulse, HI/LO just updated by an operation

Behaviour:
- Reset (async, rst=1): state=IDLE; hi=0, lo=0, busy=0, done=0; internal counter, operand and partial registers cleared. Reset mid-operation aborts immediately; no done.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0: latch op; latch |srcA|, |srcB| (two's-complement magnitude for signed ops, raw for unsigned); latch result sign and remainder sign; clear partials; counter=0; go to CALC. busy=1 from E0.
  - Otherwise, hiWrite/loWrite write wData to hi/lo at the edge; both may assert together.
  - start has priority over hiWrite/loWrite in the same cycle; the mt writes are dropped.
- CALC: one iteration per edge, E1..E{WIDTH}; counter increments; leaves for FIX when counter reaches WIDTH-1.
  - Multiply: shift-add on a 2*WIDTH-bit product.
  - Divide: restoring shift-subtract on a remainder/quotient pair.
- FIX (edge E{WIDTH+1}):
  - Apply sign correction. Product negated if signs differ. Quotient negated if signs differ. Remainder takes the dividend's sign.
  - Multiply: hi = product upper half, lo = product lower half.
  - Divide: lo = quotient, hi = remainder.
  - Go to IDLE; busy=0 and done=1 for exactly one cycle after this edge.
- Total latency: WIDTH+1 edges after E0 (33 for WIDTH=32). busy is high for WIDTH+1 cycles.
- Divide by zero (srcB=0, div or divu): lo=all ones, hi=srcA unmodified; same latency.
- Signed overflow (div, srcA=0x80000000, srcB=0xFFFFFFFF): lo=0x80000000, hi=0. Must fall out of the magnitude datapath without a special case.
- While busy:
  - start is ignored (no queueing).
  - hiWrite/loWrite are ignored; hi/lo keep their old values until FIX.
- cancel=1 while busy: return to IDLE at the next edge; busy=0 after that edge; hi/lo unchanged; no done. cancel in IDLE has no effect. cancel wins over start in the same cycle.
- hi/lo are registers, never combinationally derived from inputs.
- done is never asserted in the same cycle as busy.

Test Plan:
- Unsigned multiply: multu srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> busy high 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- Signed multiply: mult srcA=0xFFFFFFFD (-3), srcB=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed divide: div srcA=0xFFFFFFF9 (-7), srcB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide edge cases:
  - divu srcA=7, srcB=0 -> lo=0xFFFFFFFF, hi=0x00000007.
  - div srcA=0x80000000, srcB=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Busy interactions and priority:
  - Preload mthi=0x11111111 and mtlo=0x22222222 in IDLE.
  - Start multu 3*4; mid-op, pulse start (div) and hiWrite -> both ignored.
  - Final result: hi=0, lo=12, exactly one done.
  - Same-cycle start + loWrite in IDLE -> start taken, lo not written by mtlo.
- Cancel and reset:
  - cancel at CALC cycle 10 -> busy=0 next cycle, hi/lo hold prior values, no done.
  - A new start afterwards completes normally.
  - Async rst pulse between clock edges mid-CALC -> hi=lo=0, busy=0 immediately, without waiting for a clock edge.
